// File: rtl/rah_rx_app_queue.sv
// Per-application receive queue between the RAH demux (writer) and a consumer (reader).
// RAM-backed FIFO with registered flags, registered read data and sticky error flags.
`ifndef RAH_PACKET_WIDTH
`define RAH_PACKET_WIDTH 48
`endif

module rah_rx_app_queue #(
  parameter int DATA_WIDTH = `RAH_PACKET_WIDTH,
  parameter int DEPTH      = 512,
  parameter int AF_MARGIN  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     data_count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [PW-1:0]         count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // A write while full still succeeds when a pop frees the slot on the same edge.
  always_comb begin
    wr_acc     = wr_en & (~full | rd_en);
    rd_acc     = rd_en & ~empty;
    wr_ptr_nxt = wr_acc ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt = rd_acc ? rd_ptr + PW'(1) : rd_ptr;
    count_nxt  = data_count;
    if (wr_acc && !rd_acc) begin
      count_nxt = data_count + PW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = data_count - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Flags are computed from next-state pointers so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_count  <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      rd_data     <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      data_count  <= count_nxt;
      empty       <= (wr_ptr_nxt == rd_ptr_nxt);
      full        <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                     (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
      almost_full <= (count_nxt >= AF_LEVEL);
      if (rd_acc) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
      overflow    <= (overflow & ~err_clr) | (wr_en & full & ~rd_en);
      underflow   <= (underflow & ~err_clr) | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_rah_rx_app_queue.sv
// Scoreboard bench for rah_rx_app_queue: queue-based reference model, popped words
// are queued as expectations and checked by an independent rd_data monitor.
module tb_rah_rx_app_queue;

  localparam int DW    = 48;
  localparam int DEPTH = 8;
  localparam int AFM   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic [3:0]    data_count;
  logic          overflow;
  logic          underflow;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_rd = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            pop_issued = 1'b0;
  bit            pop_seen;

  rah_rx_app_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .data_count(data_count), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int n = model_q.size();
    check("empty", 64'(empty), 64'(n == 0));
    check("full", 64'(full), 64'(n == DEPTH));
    check("almost_full", 64'(almost_full), 64'(n >= DEPTH - AFM));
    check("data_count", 64'(data_count), 64'(n));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("underflow", 64'(underflow), 64'(m_unf));
  endtask

  task automatic checkReset();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_af", 64'(almost_full), 64'd0);
    check("rst_count", 64'(data_count), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_unf", 64'(underflow), 64'd0);
  endtask

  // One clock of stimulus: check state, advance the model, drive the DUT.
  task automatic applyStimulus(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr);
    int n;
    bit rd_ok, wr_ok;
    @(negedge clk);
    checkOutput();
    n     = model_q.size();
    rd_ok = rd && (n > 0);
    wr_ok = wr && ((n < DEPTH) || rd_ok);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(wd);
    m_ovf = (m_ovf && !clr) || (wr && !wr_ok);
    m_unf = (m_unf && !clr) || (rd && !rd_ok);
    wr_en      = wr;
    wr_data    = wd;
    rd_en      = rd;
    err_clr    = clr;
    pop_issued = rd_ok;
  endtask

  task automatic clearModel();
    model_q.delete();
    exp_q.delete();
    model_rd = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) pop_seen <= 1'b0;
    else     pop_seen <= pop_issued;
  end

  // rd_data must change only one cycle after a pop, to the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (pop_seen) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underrun", 64'd1, 64'd0);
        end else begin
          model_rd = exp_q.pop_front();
        end
      end
      check("rd_data", 64'(rd_data), 64'(model_rd));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pushed;
    repeat (2) @(negedge clk);
    checkReset();
    rst = 1'b0;

    // Reset mid-fill
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(48'h20 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    clearModel();
    #1 checkReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 48'hA, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Fill/drain with overflow
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Underflow and error clear
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Simultaneous push/pop at full, then on empty
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(48'h100 + i), 1'b0, 1'b0);
    for (int i = 8; i < 28; i++) applyStimulus(1'b1, DW'(48'h100 + i), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, 48'h777, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Random duty wrap stream, both sides obey flags
    pushed = 0;
    for (int cyc = 0; cyc < 2000 && (pushed < 100 || model_q.size() > 0); cyc++) begin
      bit wr, rd;
      wr = (pushed < 100) && (model_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      rd = (model_q.size() > 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(wr, DW'(48'h5000 + pushed), rd, 1'b0);
      if (wr) pushed++;
    end
    check("wrap_pushed", 64'(pushed), 64'd100);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
